fifo_drain_tx: RTL and testbench

FIFO_DRAIN_TX -- requirements
Module: fifo_drain_tx

---
 rtl/fifo_drain_tx.sv | 143 ++++++++++++++
 tb/tb_fifo_drain_tx.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_tx.sv
// fifo_drain_tx: pops one word from a FIFO, then sends it as a UART-style
// frame. The frame is a start bit (0), DATA_WIDTH data bits LSB first and a
// stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
// state | meaning
// IDLE  | line high, waiting for en and a non-empty FIFO
// POP   | rinc pulse, pop committed
// WAIT  | extra read-latency cycles before rdata is valid
// START | start bit, word captured on entry
// DATA  | data bits, LSB first
// STOP  | stop bit, frame_done on its last cycle
module fifo_drain_tx #(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int READ_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            words_sent
);

  // 8 bits covers CLKS_PER_BIT up to 255 and READ_LAT up to 3.
  localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] WAIT_LAST = 8'((READ_LAT >= 2) ? (READ_LAT - 2) : 0);
  localparam int         IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shreg;
  // Blocks a pop on the first edge after reset release.
  logic                  armed;

  // Sequencer: pop, wait out read latency, then shift the frame out.
  // The captured word is never rewritten during a frame; idx selects the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      armed      <= 1'b0;
      rinc       <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      words_sent <= '0;
    end else begin
      armed      <= 1'b1;
      rinc       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && en && !empty) begin
            state <= POP;
            rinc  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        POP: begin
          if (READ_LAT == 1) begin
            state <= START;
            shreg <= rdata;
            tx    <= 1'b0;
            cnt   <= BIT_LAST;
          end else begin
            state <= WAIT;
            cnt   <= WAIT_LAST;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state <= START;
            shreg <= rdata;
            tx    <= 1'b0;
            cnt   <= BIT_LAST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        START: begin
          if (cnt == 8'd0) begin
            state <= DATA;
            idx   <= '0;
            tx    <= shreg[0];
            cnt   <= BIT_LAST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DATA: begin
          if (cnt == 8'd0) begin
            cnt <= BIT_LAST;
            if (idx == IDX_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              tx  <= shreg[idx + 1'b1];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STOP: begin
          if (cnt == 8'd1) begin
            frame_done <= 1'b1;
            words_sent <= words_sent + 8'd1;
          end
          if (cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Testbench for fifo_drain_tx. DUT a uses READ_LAT=1 and a queue-based FIFO
// model. DUT b uses READ_LAT=3 with hand-driven rdata timing.
module tb_fifo_drain_tx;

  localparam int CPB   = 4;
  localparam int FLEN  = 6 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       en_a = 1'b0, empty_a = 1'b1;
  logic [3:0] rdata_a = 4'h0;
  logic       rinc_a, tx_a, busy_a, fd_a;
  logic [7:0] ws_a;

  logic       en_b = 1'b0, empty_b = 1'b1;
  logic [3:0] rdata_b = 4'h0;
  logic       rinc_b, tx_b, busy_b, fd_b;
  logic [7:0] ws_b;

  int n_vec = 0;
  int n_err = 0;
  int rinc_cnt_a = 0;
  int rinc_cnt_b = 0;
  int ws_exp_a = 0;
  logic [3:0] q[$];
  bit pop_pend = 1'b0;

  fifo_drain_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .empty(empty_a), .rdata(rdata_a),
    .rinc(rinc_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a), .words_sent(ws_a)
  );

  fifo_drain_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .READ_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .empty(empty_b), .rdata(rdata_b),
    .rinc(rinc_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b), .words_sent(ws_b)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model for DUT a: the head is presented on rdata, and it
  // is removed half a cycle after the edge that saw rinc.
  always @(negedge clk) begin
    logic [3:0] tmp;
    if (rinc_a) rinc_cnt_a++;
    if (rinc_b) rinc_cnt_b++;
    if (pop_pend && q.size() > 0) tmp = q.pop_front();
    pop_pend = rinc_a;
    empty_a  = (q.size() == 0);
    rdata_a  = (q.size() > 0) ? q[0] : 4'h0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic tx_of(input int w);
    return (w != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic busy_of(input int w);
    return (w != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic fd_of(input int w);
    return (w != 0) ? fd_b : fd_a;
  endfunction

  // Waits for a start bit, then records one full frame.
  // gap  : tx-high samples seen before the start bit.
  // idle : samples with busy low among those.
  // shape: samples that break the expected bit/busy pattern.
  task automatic collect_frame(input int w, output bit got, output logic [3:0] payload,
                               output int shape, output int fd_cnt, output int fd_last,
                               output int gap, output int idle);
    logic b;
    int bp;
    got = 1'b0; payload = 4'h0; shape = 0; fd_cnt = 0; fd_last = 0; gap = 0; idle = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (tx_of(w) == 1'b0) got = 1'b1;
      else begin
        gap++;
        if (!busy_of(w)) idle++;
      end
    end
    if (!got) return;
    for (int c = 0; c < FLEN; c++) begin
      if (c > 0) @(negedge clk);
      b  = tx_of(w);
      bp = c / CPB;
      if (bp == 0) begin
        if (b !== 1'b0) shape++;
      end else if (bp == 5) begin
        if (b !== 1'b1) shape++;
      end else if (c % CPB == 0) begin
        payload[bp-1] = b;
      end else if (b !== payload[bp-1]) begin
        shape++;
      end
      if (busy_of(w) !== 1'b1) shape++;
      if (fd_of(w) === 1'b1) begin
        fd_cnt++;
        if (c == FLEN - 1) fd_last = 1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL reset_tx_a got=%b exp=1", tx_a); end
    n_vec++; if (rinc_a !== 1'b0) begin n_err++; $display("FAIL reset_rinc_a got=%b exp=0", rinc_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    n_vec++; if (fd_a !== 1'b0) begin n_err++; $display("FAIL reset_fd_a got=%b exp=0", fd_a); end
    n_vec++; if (ws_a !== 8'd0) begin n_err++; $display("FAIL reset_ws_a got=%0d exp=0", ws_a); end
    n_vec++; if ({tx_b, rinc_b, busy_b, fd_b} !== 4'b1000) begin
      n_err++; $display("FAIL reset_b tx/rinc/busy/fd got=%b exp=1000", {tx_b, rinc_b, busy_b, fd_b});
    end
    n_vec++; if (ws_b !== 8'd0) begin n_err++; $display("FAIL reset_ws_b got=%0d exp=0", ws_b); end
  endtask

  task automatic test_single_frame();
    bit got, seen;
    logic [3:0] pl;
    int shape, fdc, fdl, gap, idle, r0;
    q.push_back(4'b1011);
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    r0 = rinc_cnt_a;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (rinc_a !== 1'b0) begin n_err++; $display("FAIL first_edge_pop rinc got=%b exp=0", rinc_a); end
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      @(negedge clk);
      if (rinc_a) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL single_pop_seen got=%b exp=1", seen); end
    collect_frame(0, got, pl, shape, fdc, fdl, gap, idle);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL single_start got=%b exp=1", got); end
    n_vec++; if (pl !== 4'b1011) begin n_err++; $display("FAIL single_payload got=%h exp=b", pl); end
    n_vec++; if (shape !== 0) begin n_err++; $display("FAIL single_shape errs=%0d exp=0", shape); end
    n_vec++; if (fdc !== 1 || fdl !== 1) begin
      n_err++; $display("FAIL single_frame_done pulses=%0d on_last=%0d exp=1/1", fdc, fdl);
    end
    en_a = 1'b0;
    ws_exp_a = (ws_exp_a + 1) % 256;
    repeat (4) @(negedge clk);
    n_vec++; if (ws_a !== 8'(ws_exp_a)) begin n_err++; $display("FAIL single_words_sent got=%0d exp=%0d", ws_a, ws_exp_a); end
    n_vec++; if (rinc_cnt_a - r0 !== 1) begin n_err++; $display("FAIL single_rinc_pulses got=%0d exp=1", rinc_cnt_a - r0); end
  endtask

  task automatic test_empty_idle();
    int r_hi, tx_lo, b_hi;
    r_hi = 0; tx_lo = 0; b_hi = 0;
    en_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rinc_a) r_hi++;
      if (!tx_a) tx_lo++;
      if (busy_a) b_hi++;
    end
    n_vec++; if (r_hi !== 0) begin n_err++; $display("FAIL empty_rinc cycles_high=%0d exp=0", r_hi); end
    n_vec++; if (tx_lo !== 0) begin n_err++; $display("FAIL empty_tx cycles_low=%0d exp=0", tx_lo); end
    n_vec++; if (b_hi !== 0) begin n_err++; $display("FAIL empty_busy cycles_high=%0d exp=0", b_hi); end
  endtask

  task automatic run_stream(input string name, input int n, input logic [3:0] words[8]);
    bit got;
    logic [3:0] pl;
    int shape, fdc, fdl, gap, idle, r0;
    r0 = rinc_cnt_a;
    for (int i = 0; i < n; i++) q.push_back(words[i]);
    en_a = 1'b1;
    for (int i = 0; i < n; i++) begin
      collect_frame(0, got, pl, shape, fdc, fdl, gap, idle);
      n_vec++; if (got !== 1'b1 || pl !== words[i]) begin
        n_err++; $display("FAIL %s_payload[%0d] got=%h (start=%b) exp=%h", name, i, pl, got, words[i]);
      end
      n_vec++; if (shape !== 0 || fdc !== 1 || fdl !== 1) begin
        n_err++; $display("FAIL %s_shape[%0d] errs=%0d fd_pulses=%0d fd_last=%0d exp=0/1/1", name, i, shape, fdc, fdl);
      end
      if (i > 0) begin
        n_vec++; if (gap !== 2 || idle !== 1) begin
          n_err++; $display("FAIL %s_gap[%0d] gap=%0d idle=%0d exp=2/1", name, i, gap, idle);
        end
      end
      ws_exp_a = (ws_exp_a + 1) % 256;
    end
    repeat (10) @(negedge clk);
    en_a = 1'b0;
    n_vec++; if (ws_a !== 8'(ws_exp_a)) begin n_err++; $display("FAIL %s_words_sent got=%0d exp=%0d", name, ws_a, ws_exp_a); end
    n_vec++; if (rinc_cnt_a - r0 !== n) begin n_err++; $display("FAIL %s_rinc_pulses got=%0d exp=%0d", name, rinc_cnt_a - r0, n); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w[8];
    w = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_stream("b2b", 3, w);
  endtask

  task automatic test_random_stream();
    logic [3:0] w[8];
    int n;
    for (int rep = 0; rep < 3; rep++) begin
      n = $urandom_range(2, 6);
      for (int i = 0; i < 8; i++) w[i] = 4'($urandom_range(0, 15));
      run_stream("rand", n, w);
    end
  endtask

  task automatic test_abort_ignored();
    bit got, seen;
    logic [3:0] pl;
    int shape, fdc, fdl, gap, idle, r0, k;
    r0 = rinc_cnt_a;
    k  = $urandom_range(5, 19);
    q.push_back(4'hA);
    q.push_back(4'($urandom_range(0, 15)));
    en_a = 1'b1;
    fork
      collect_frame(0, got, pl, shape, fdc, fdl, gap, idle);
      begin
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (!tx_a) seen = 1'b1;
        end
        repeat (k) @(negedge clk);
        en_a = 1'b0;
        q.delete();
      end
    join
    ws_exp_a = (ws_exp_a + 1) % 256;
    n_vec++; if (got !== 1'b1 || pl !== 4'hA) begin
      n_err++; $display("FAIL abort_payload got=%h (start=%b) exp=a", pl, got);
    end
    n_vec++; if (shape !== 0 || fdc !== 1 || fdl !== 1) begin
      n_err++; $display("FAIL abort_shape errs=%0d fd_pulses=%0d fd_last=%0d exp=0/1/1", shape, fdc, fdl);
    end
    repeat (40) @(negedge clk);
    n_vec++; if (rinc_cnt_a - r0 !== 1) begin n_err++; $display("FAIL abort_rinc_pulses got=%0d exp=1", rinc_cnt_a - r0); end
    n_vec++; if (ws_a !== 8'(ws_exp_a)) begin n_err++; $display("FAIL abort_words_sent got=%0d exp=%0d", ws_a, ws_exp_a); end
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    logic [3:0] w;
    int fd_seen, b_hi;
    w = 4'($urandom_range(0, 15)) & 4'b1011;
    q.push_back(w);
    en_a = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (!tx_a) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstmid_start got=%b exp=1", seen); end
    repeat (3 * CPB + 1) @(negedge clk);
    n_vec++; if (tx_a !== 1'b0) begin n_err++; $display("FAIL rstmid_bit2 tx got=%b exp=0", tx_a); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (tx_a !== 1'b1) begin n_err++; $display("FAIL rstmid_tx got=%b exp=1", tx_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy_a); end
    n_vec++; if (ws_a !== 8'd0) begin n_err++; $display("FAIL rstmid_words_sent got=%0d exp=0", ws_a); end
    ws_exp_a = 0;
    en_a = 1'b0;
    fd_seen = 0; b_hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (fd_a) fd_seen++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (fd_a) fd_seen++;
      if (busy_a || !tx_a) b_hi++;
    end
    n_vec++; if (fd_seen !== 0) begin n_err++; $display("FAIL rstmid_frame_done pulses=%0d exp=0", fd_seen); end
    n_vec++; if (b_hi !== 0) begin n_err++; $display("FAIL rstmid_idle_after cycles_active=%0d exp=0", b_hi); end
    n_vec++; if (ws_a !== 8'd0) begin n_err++; $display("FAIL rstmid_words_after got=%0d exp=0", ws_a); end
  endtask

  task automatic test_read_latency3();
    bit got, seen;
    logic [3:0] pl, w, j1, j2, j3;
    int shape, fdc, fdl, gap, idle, ws_exp_b, r0;
    ws_exp_b = 0;
    r0 = rinc_cnt_b;
    for (int it = 0; it < 4; it++) begin
      w  = 4'($urandom_range(0, 14));
      j1 = ~w; j2 = w ^ 4'($urandom_range(1, 15)); j3 = w ^ 4'h5;
      rdata_b = j1;
      empty_b = 1'b0;
      en_b    = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
        @(negedge clk);
        if (rinc_b) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL lat3_pop[%0d] got=%b exp=1", it, seen); end
      empty_b = 1'b1;
      fork
        collect_frame(1, got, pl, shape, fdc, fdl, gap, idle);
        begin
          rdata_b = j3;
          @(negedge clk);
          rdata_b = j2;
          @(negedge clk);
          rdata_b = w;
          @(negedge clk);
          rdata_b = 4'hF;
        end
      join
      ws_exp_b = (ws_exp_b + 1) % 256;
      n_vec++; if (got !== 1'b1 || pl !== w) begin
        n_err++; $display("FAIL lat3_payload[%0d] got=%h (start=%b) exp=%h", it, pl, got, w);
      end
      n_vec++; if (shape !== 0 || fdc !== 1 || fdl !== 1 || gap !== 2) begin
        n_err++; $display("FAIL lat3_shape[%0d] errs=%0d fd=%0d last=%0d wait=%0d exp=0/1/1/2", it, shape, fdc, fdl, gap);
      end
      repeat (5) @(negedge clk);
    end
    n_vec++; if (ws_b !== 8'(ws_exp_b)) begin n_err++; $display("FAIL lat3_words_sent got=%0d exp=%0d", ws_b, ws_exp_b); end
    n_vec++; if (rinc_cnt_b - r0 !== 4) begin n_err++; $display("FAIL lat3_rinc_pulses got=%0d exp=4", rinc_cnt_b - r0); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_empty_idle();
    test_back_to_back();
    test_random_stream();
    test_abort_ignored();
    test_reset_mid_frame();
    test_read_latency3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
